// File: rtl/rc_read_tag_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rc_read_tag_scheduler
// Description : Round-robin arbiter for DMA read requests. It allocates a
//               unique PCIe tag to each read, records the owner of every
//               outstanding tag, routes completion headers to the owning
//               requester and frees the tag on the last completion.
// Revision    : 1.0 - initial release
// ============================================================================
module rc_read_tag_scheduler #(
    parameter int NREQ      = 2,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 user_clk_i,
    input  logic                 user_reset_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic                 rq_valid_o,
    input  logic                 rq_ready_i,
    output logic [TAG_WIDTH-1:0] rq_tag_o,
    output logic [2:0]           rq_src_o,
    input  logic                 cpl_valid_i,
    input  logic [TAG_WIDTH-1:0] cpl_tag_i,
    input  logic [2:0]           cpl_status_i,
    input  logic [11:0]          cpl_bytecnt_i,
    input  logic [9:0]           cpl_dwlen_i,
    input  logic [1:0]           cpl_lowaddr_i,
    output logic                 cpl_dst_valid_o,
    output logic [2:0]           cpl_dst_o,
    output logic                 cpl_final_o,
    output logic                 cpl_err_o,
    output logic [TAG_WIDTH:0]   tags_free_o
);

    localparam int NTAGS = 2**TAG_WIDTH;

    // Tag pool state
    logic [NTAGS-1:0]     busy_q;
    logic [NTAGS-1:0]     busy_d;
    logic [2:0]           owner_q [NTAGS];
    logic [TAG_WIDTH:0]   tags_free_q;
    logic [TAG_WIDTH:0]   tags_free_d;

    // Arbitration state
    logic [2:0]           rr_q;
    logic [2:0]           rr_d;

    // Output register
    logic                 rq_valid_q;
    logic [TAG_WIDTH-1:0] rq_tag_q;
    logic [2:0]           rq_src_q;

    // Completion result registers
    logic                 cpl_dst_valid_q;
    logic [2:0]           cpl_dst_q;
    logic                 cpl_final_q;
    logic                 cpl_err_q;

    // Combinational decisions
    logic                 free_found;
    logic [TAG_WIDTH-1:0] free_tag;
    logic                 win_found;
    logic [2:0]           win_idx;
    int                   win_dist;
    int                   cand_dist;
    logic                 grant_ok;
    logic [12:0]          bytes_rem;
    logic [12:0]          dw_bytes;
    logic [13:0]          bytes_end;
    logic                 cpl_last;
    logic                 cpl_tag_busy;
    logic                 cpl_hit;
    logic                 cpl_free;

    // Lowest-index free tag, taken from the busy vector before this cycle's release
    always_comb begin
        free_found = 1'b0;
        free_tag   = '0;
        for (int t = NTAGS - 1; t >= 0; t--) begin
            if (!busy_q[t]) begin
                free_found = 1'b1;
                free_tag   = TAG_WIDTH'(t);
            end
        end
    end

    // Round-robin winner: smallest rotated distance from rr among valid requesters
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_dist  = NREQ;
        cand_dist = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand_dist = (i >= int'(rr_q)) ? (i - int'(rr_q)) : (i + NREQ - int'(rr_q));
            if (req_valid_i[i] && (cand_dist < win_dist)) begin
                win_dist  = cand_dist;
                win_found = 1'b1;
                win_idx   = 3'(i);
            end
        end
    end

    // Grant only when a tag is available and the output slot is empty or draining;
    // grants are suppressed while reset is held so no handshake is lost.
    always_comb begin
        grant_ok = win_found && free_found && (!rq_valid_q || rq_ready_i) && !user_reset_i;
        for (int i = 0; i < NREQ; i++) begin
            req_ready_o[i] = grant_ok && (win_idx == 3'(i));
        end
        rr_d = (win_idx == 3'(NREQ - 1)) ? 3'd0 : (win_idx + 3'd1);
    end

    // Last-completion detection with 0-encodes-max fields and 14-bit compare
    always_comb begin
        bytes_rem    = (cpl_bytecnt_i == 12'd0) ? 13'd4096 : {1'b0, cpl_bytecnt_i};
        dw_bytes     = (cpl_dwlen_i == 10'd0) ? 13'd4096 : {1'b0, cpl_dwlen_i, 2'b00};
        bytes_end    = {1'b0, bytes_rem} + {12'd0, cpl_lowaddr_i};
        cpl_last     = (cpl_status_i != 3'b000) || (bytes_end <= {1'b0, dw_bytes});
        cpl_tag_busy = busy_q[cpl_tag_i];
        cpl_hit      = cpl_valid_i && cpl_tag_busy;
        cpl_free     = cpl_hit && cpl_last;
    end

    // Next busy vector and free count; allocation and release never touch the same tag
    always_comb begin
        busy_d = busy_q;
        if (grant_ok) begin
            busy_d[free_tag] = 1'b1;
        end
        if (cpl_free) begin
            busy_d[cpl_tag_i] = 1'b0;
        end
        tags_free_d = tags_free_q - {{TAG_WIDTH{1'b0}}, grant_ok} + {{TAG_WIDTH{1'b0}}, cpl_free};
    end

    // Tag pool, owner table, free counter and round-robin pointer
    always_ff @(posedge user_clk_i or posedge user_reset_i) begin
        if (user_reset_i) begin
            busy_q      <= '0;
            tags_free_q <= (TAG_WIDTH + 1)'(NTAGS);
            rr_q        <= 3'd0;
            for (int t = 0; t < NTAGS; t++) begin
                owner_q[t] <= 3'd0;
            end
        end else begin
            busy_q      <= busy_d;
            tags_free_q <= tags_free_d;
            if (grant_ok) begin
                owner_q[free_tag] <= win_idx;
                rr_q              <= rr_d;
            end
        end
    end

    // Request output register: loads on grant, holds until drained
    always_ff @(posedge user_clk_i or posedge user_reset_i) begin
        if (user_reset_i) begin
            rq_valid_q <= 1'b0;
            rq_tag_q   <= '0;
            rq_src_q   <= 3'd0;
        end else if (grant_ok) begin
            rq_valid_q <= 1'b1;
            rq_tag_q   <= free_tag;
            rq_src_q   <= win_idx;
        end else if (rq_ready_i) begin
            rq_valid_q <= 1'b0;
        end
    end

    // Completion routing results, one cycle after the header beat
    always_ff @(posedge user_clk_i or posedge user_reset_i) begin
        if (user_reset_i) begin
            cpl_dst_valid_q <= 1'b0;
            cpl_dst_q       <= 3'd0;
            cpl_final_q     <= 1'b0;
            cpl_err_q       <= 1'b0;
        end else begin
            cpl_dst_valid_q <= cpl_hit;
            cpl_final_q     <= cpl_free;
            cpl_err_q       <= cpl_valid_i && !cpl_tag_busy;
            if (cpl_hit) begin
                cpl_dst_q <= owner_q[cpl_tag_i];
            end
        end
    end

    assign rq_valid_o      = rq_valid_q;
    assign rq_tag_o        = rq_tag_q;
    assign rq_src_o        = rq_src_q;
    assign cpl_dst_valid_o = cpl_dst_valid_q;
    assign cpl_dst_o       = cpl_dst_q;
    assign cpl_final_o     = cpl_final_q;
    assign cpl_err_o       = cpl_err_q;
    assign tags_free_o     = tags_free_q;

endmodule
`default_nettype wire

// File: tb/tb_rc_read_tag_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rc_read_tag_scheduler
// Description : Directed bench for rc_read_tag_scheduler (NREQ=2, 32 tags).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rc_read_tag_scheduler;

    localparam int NREQ = 2;
    localparam int TW   = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ-1:0] req_ready;
    logic          rq_valid;
    logic          rq_ready = 1'b1;
    logic [TW-1:0] rq_tag;
    logic [2:0]    rq_src;
    logic          cpl_valid = 1'b0;
    logic [TW-1:0] cpl_tag = '0;
    logic [2:0]    cpl_status = '0;
    logic [11:0]   cpl_bytecnt = '0;
    logic [9:0]    cpl_dwlen = '0;
    logic [1:0]    cpl_lowaddr = '0;
    logic          cpl_dst_valid;
    logic [2:0]    cpl_dst;
    logic          cpl_final;
    logic          cpl_err;
    logic [TW:0]   tags_free;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rc_read_tag_scheduler #(.NREQ(NREQ), .TAG_WIDTH(TW)) dut (
        .user_clk_i      (clk),
        .user_reset_i    (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .rq_valid_o      (rq_valid),
        .rq_ready_i      (rq_ready),
        .rq_tag_o        (rq_tag),
        .rq_src_o        (rq_src),
        .cpl_valid_i     (cpl_valid),
        .cpl_tag_i       (cpl_tag),
        .cpl_status_i    (cpl_status),
        .cpl_bytecnt_i   (cpl_bytecnt),
        .cpl_dwlen_i     (cpl_dwlen),
        .cpl_lowaddr_i   (cpl_lowaddr),
        .cpl_dst_valid_o (cpl_dst_valid),
        .cpl_dst_o       (cpl_dst),
        .cpl_final_o     (cpl_final),
        .cpl_err_o       (cpl_err),
        .tags_free_o     (tags_free)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cpl(input logic [TW-1:0] tag, input logic [2:0] st,
                            input logic [11:0] bc, input logic [9:0] dwl, input logic [1:0] la);
        cpl_valid   = 1'b1;
        cpl_tag     = tag;
        cpl_status  = st;
        cpl_bytecnt = bc;
        cpl_dwlen   = dwl;
        cpl_lowaddr = la;
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_rq_valid"},  32'(rq_valid),      32'd0);
        chk({pfx, "_rq_tag"},    32'(rq_tag),        32'd0);
        chk({pfx, "_rq_src"},    32'(rq_src),        32'd0);
        chk({pfx, "_dst_valid"}, 32'(cpl_dst_valid), 32'd0);
        chk({pfx, "_dst"},       32'(cpl_dst),       32'd0);
        chk({pfx, "_final"},     32'(cpl_final),     32'd0);
        chk({pfx, "_err"},       32'(cpl_err),       32'd0);
        chk({pfx, "_tags_free"}, 32'(tags_free),     32'd32);
        chk({pfx, "_req_ready"}, 32'(req_ready),     32'd0);
    endtask

    initial begin
        // Reset state
        cyc();
        cyc();
        chk_reset_state("rst");
        rst = 1'b0;

        // Alternating grants with tags 0..3
        req_valid = 2'b11;
        #1;
        chk("first_req_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("alt_rq_valid", 32'(rq_valid), 32'd1);
            chk("alt_rq_tag",   32'(rq_tag),   32'(k));
            chk("alt_rq_src",   32'(rq_src),   32'(k % 2));
            chk("alt_free",     32'(tags_free), 32'(31 - k));
        end

        // Exhaust the pool with requester 0
        req_valid = 2'b01;
        for (int k = 0; k < 28; k++) begin
            cyc();
            chk("exh_rq_tag", 32'(rq_tag), 32'(4 + k));
            chk("exh_rq_src", 32'(rq_src), 32'd0);
        end
        chk("exh_free",      32'(tags_free), 32'd0);
        chk("exh_req_ready", 32'(req_ready), 32'd0);

        // Final completion on tag 7 frees it; no grant in the release cycle
        send_cpl(5'd7, 3'b000, 12'd4, 10'd1, 2'd0);
        cyc();
        chk("t7_dst_valid", 32'(cpl_dst_valid), 32'd1);
        chk("t7_dst",       32'(cpl_dst),       32'd0);
        chk("t7_final",     32'(cpl_final),     32'd1);
        chk("t7_err",       32'(cpl_err),       32'd0);
        chk("t7_free",      32'(tags_free),     32'd1);
        chk("t7_rq_tag_old", 32'(rq_tag),       32'd31);
        cpl_valid = 1'b0;
        #1;
        chk("t7_req_ready", 32'(req_ready), 32'd1);
        cyc();
        chk("t7_realloc_tag", 32'(rq_tag),    32'd7);
        chk("t7_realloc_src", 32'(rq_src),    32'd0);
        chk("t7_realloc_free", 32'(tags_free), 32'd0);
        req_valid = 2'b00;

        // Split completion on tag 3 (owned by requester 1)
        send_cpl(5'd3, 3'b000, 12'd512, 10'd64, 2'd0);
        cyc();
        chk("split1_dst_valid", 32'(cpl_dst_valid), 32'd1);
        chk("split1_dst",       32'(cpl_dst),       32'd1);
        chk("split1_final",     32'(cpl_final),     32'd0);
        chk("split1_free",      32'(tags_free),     32'd0);
        send_cpl(5'd3, 3'b000, 12'd256, 10'd64, 2'd0);
        cyc();
        chk("split2_final", 32'(cpl_final), 32'd1);
        chk("split2_dst",   32'(cpl_dst),   32'd1);
        chk("split2_free",  32'(tags_free), 32'd1);

        // Error status frees a busy tag; completion on a free tag flags an error
        send_cpl(5'd2, 3'b001, 12'd0, 10'd1, 2'd0);
        cyc();
        chk("errst_final", 32'(cpl_final), 32'd1);
        chk("errst_err",   32'(cpl_err),   32'd0);
        chk("errst_dst",   32'(cpl_dst),   32'd0);
        chk("errst_free",  32'(tags_free), 32'd2);
        send_cpl(5'd3, 3'b000, 12'd4, 10'd1, 2'd0);
        cyc();
        chk("freetag_err",       32'(cpl_err),       32'd1);
        chk("freetag_dst_valid", 32'(cpl_dst_valid), 32'd0);
        chk("freetag_final",     32'(cpl_final),     32'd0);
        chk("freetag_free",      32'(tags_free),     32'd2);

        // Boundary arithmetic on tag 1 (owned by requester 1)
        send_cpl(5'd1, 3'b000, 12'd4, 10'd1, 2'd1);
        cyc();
        chk("bnd_la_final",     32'(cpl_final),     32'd0);
        chk("bnd_la_dst_valid", 32'(cpl_dst_valid), 32'd1);
        chk("bnd_la_err",       32'(cpl_err),       32'd0);
        send_cpl(5'd1, 3'b000, 12'd0, 10'd0, 2'd0);
        cyc();
        chk("bnd_4k_final", 32'(cpl_final), 32'd1);
        chk("bnd_4k_dst",   32'(cpl_dst),   32'd1);
        chk("bnd_4k_free",  32'(tags_free), 32'd3);
        cpl_valid = 1'b0;

        // Backpressure: rr points at requester 1, free tags are 1,2,3
        rq_ready  = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("bp_first_ready", 32'(req_ready), 32'd2);
        cyc();
        chk("bp_rq_valid", 32'(rq_valid),  32'd1);
        chk("bp_rq_tag",   32'(rq_tag),    32'd1);
        chk("bp_rq_src",   32'(rq_src),    32'd1);
        chk("bp_free",     32'(tags_free), 32'd2);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("bp_hold_valid", 32'(rq_valid),  32'd1);
            chk("bp_hold_tag",   32'(rq_tag),    32'd1);
            chk("bp_hold_src",   32'(rq_src),    32'd1);
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
            chk("bp_hold_free",  32'(tags_free), 32'd2);
        end

        // Same-cycle release of tag 0 and allocation: allocation takes tag 2
        send_cpl(5'd0, 3'b000, 12'd4, 10'd1, 2'd0);
        rq_ready = 1'b1;
        #1;
        chk("sim_req_ready", 32'(req_ready), 32'd1);
        cyc();
        chk("sim_rq_tag", 32'(rq_tag),    32'd2);
        chk("sim_rq_src", 32'(rq_src),    32'd0);
        chk("sim_final",  32'(cpl_final), 32'd1);
        chk("sim_dst",    32'(cpl_dst),   32'd0);
        chk("sim_free",   32'(tags_free), 32'd2);
        cpl_valid = 1'b0;
        cyc();
        chk("after_rel_tag",  32'(rq_tag),    32'd0);
        chk("after_rel_src",  32'(rq_src),    32'd1);
        chk("after_rel_free", 32'(tags_free), 32'd1);

        // Reset mid-stream
        rst = 1'b1;
        #1;
        chk_reset_state("midrst");
        cyc();
        cyc();
        rst       = 1'b0;
        req_valid = 2'b00;

        // Completion after reset hits a free tag
        send_cpl(5'd5, 3'b000, 12'd4, 10'd1, 2'd0);
        cyc();
        chk("postrst_err",       32'(cpl_err),       32'd1);
        chk("postrst_dst_valid", 32'(cpl_dst_valid), 32'd0);
        chk("postrst_final",     32'(cpl_final),     32'd0);
        cpl_valid = 1'b0;
        req_valid = 2'b11;
        cyc();
        chk("postrst_rq_tag", 32'(rq_tag),    32'd0);
        chk("postrst_rq_src", 32'(rq_src),    32'd0);
        chk("postrst_free",   32'(tags_free), 32'd31);
        req_valid = 2'b00;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rc_read_tag_scheduler.md
# rc_read_tag_scheduler

Arbitrates memory-read requests from several DMA requesters onto the single PCIe requester-request path and allocates a unique tag to each read. It tracks every outstanding tag and its owner, and watches the completion headers leaving the RC adapter. Each completion is routed to the requester that owns its tag, and the tag is freed on the final completion of its read. The block sits beside the RC completion adapter, between the DMA readers and the RQ/RC interfaces of the Xilinx PHY.

## Interface
- NREQ, 2, number of requesters (1..8)
- TAG_WIDTH, 5, tag width; NTAGS = 2**TAG_WIDTH tags in the pool
- user_clk  in  1  clock
- user_reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester read request pending
- req_ready  out  NREQ  one-hot grant; the request is accepted when req_valid[i] & req_ready[i]
- rq_valid  out  1  allocated request available downstream
- rq_ready  in  1  downstream accepts the rq_* beat
- rq_tag  out  TAG_WIDTH  tag allocated to the request
- rq_src  out  3  index of the granted requester
- cpl_valid  in  1  completion header beat (first beat of a completion TLP)
- cpl_tag  in  TAG_WIDTH  completion tag
- cpl_status  in  3  completion status; 000 = SC
- cpl_bytecnt  in  12  remaining byte count; 0 encodes 4096
- cpl_dwlen  in  10  payload DW length; 0 encodes 1024
- cpl_lowaddr  in  2  lower address bits [1:0]
- cpl_dst_valid  out  1  routing result valid (one-cycle pulse)
- cpl_dst  out  3  owner index of the completion's tag
- cpl_final  out  1  this completion freed its tag
- cpl_err  out  1  error pulse: completion on a free tag
- tags_free  out  TAG_WIDTH+1  number of free tags

## Operation
- State per tag: busy bit and owner field (3 bits). All tags are free after reset.
- Allocation:
  - The chosen tag is the lowest-index free tag, combinational on the busy vector at the start of the cycle.
  - A tag freed in cycle N becomes allocatable in cycle N+1, never in the same cycle.
- Arbitration:
  - Round-robin pointer rr (0..NREQ-1), reset to 0.
  - The winner is the first i with req_valid[i] set, searching from rr upward with wrap.
  - req_ready is asserted only for the winner, and only when a free tag exists and the output register is empty or being drained (rq_valid & rq_ready).
  - On accept: rr <= winner+1 (mod NREQ). The tag's busy bit is set and its owner is set to the winner. rq_valid, rq_tag and rq_src are loaded.
- Output register:
  - rq_valid holds with stable rq_tag and rq_src until rq_ready.
  - Backpressure blocks further grants; tags are still held busy.
- Completion handling, on cpl_valid in cycle N, registered into cycle N+1:
  - cpl_dst_valid = 1 and cpl_dst = owner[cpl_tag].
  - final = (cpl_status != 000) OR (bytes_rem + cpl_lowaddr <= dw_bytes):
    - bytes_rem = cpl_bytecnt, 13-bit, with 0 -> 4096.
    - dw_bytes = 4*cpl_dwlen, 13-bit, with 0 -> 4096.
    - The comparison uses 14-bit arithmetic; no truncation.
  - When final: cpl_final = 1 and the tag's busy bit clears at the end of cycle N.
  - If the tag is not busy: cpl_err = 1, cpl_dst_valid = 0, and there is no state change.
- Simultaneous events:
  - An allocation and a release of different tags in the same cycle are both applied.
  - Allocation can never target the tag being released, because allocation sees the pre-release busy vector.
- tags_free = NTAGS − popcount(busy). It is registered and reflects both updates one cycle after the edge.

## Timing
- Reset values (async assert, sync-released use): rq_valid 0, rq_tag 0, rq_src 0, cpl_dst_valid 0, cpl_dst 0, cpl_final 0, cpl_err 0, tags_free NTAGS, rr 0, all busy bits 0.
- Grant to rq_valid: 1 cycle (accept at edge N, rq_valid high in N+1). Sustained throughput is 1 request per cycle when rq_ready = 1.
- Completion to routing: 1 cycle.
- Reset mid-operation clears all busy tags and drops the pending rq beat immediately. Completions arriving after reset raise cpl_err.
- req_ready never depends on rq_valid's own next state; there is no combinational loop through rq_ready beyond the drain term.

## Test plan
- Reset, then req_valid = 2'b11 held with rq_ready = 1 -> grants alternate 0,1,0,1; rq_tag = 0,1,2,3; tags_free decrements to NTAGS−4.
- Exhaust the pool: 32 accepts with no completions -> req_ready = 0 and tags_free = 0. A final completion on tag 7 -> next grant one cycle later gets rq_tag = 7.
- Split completion on a 512-byte read (tag 3):
  - First completion: bytecnt = 512, dwlen = 64, lowaddr = 0 -> cpl_final = 0.
  - Second completion: bytecnt = 256, dwlen = 64 -> cpl_final = 1, tag 3 freed.
- Error completion: status = 001 on a busy tag -> cpl_final = 1, tag freed, cpl_err = 0. A completion on a free tag -> cpl_err = 1, cpl_dst_valid = 0.
- Boundary arithmetic: bytecnt = 0 (4096), dwlen = 0 (1024 DW), lowaddr = 0 -> final. bytecnt = 4, dwlen = 1, lowaddr = 1 -> not final.
- Backpressure: rq_ready = 0 for 5 cycles with requests pending -> rq_valid, rq_tag and rq_src stable, req_ready = 0. A same-cycle release of tag 0 and allocation -> the allocation picks a different tag. Reset asserted mid-stream -> all outputs return to reset values.
